// File: rtl/zigbee_pkg.sv
// Shared types and the 802.15.4 symbol-0 PN sequence used by the spreader and
// the chip lookup.
package zigbee_pkg;

  typedef logic [3:0] symbol_t;
  typedef logic [4:0] chip_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } spread_state_t;

  // c0 is the leftmost bit, so index [0] is the first chip on air.
  localparam logic [0:31] CHIP_SEQ_0 = 32'b1101_1001_1100_0011_0101_0010_0010_1110;

endpackage

// File: rtl/zigbee_chip_lut.sv
// Combinational symbol -> 32-chip PN lookup. Symbols 1-7 are right rotations of
// symbol 0 by 4 chips per step, and symbols 8-15 invert the odd chips of symbol k-8.
module zigbee_chip_lut
  import zigbee_pkg::*;
(
  input  symbol_t      sym_i,
  output logic [0:31]  chips_o
);

  chip_idx_t rot;
  assign rot = {sym_i[2:0], 2'b00};

  for (genvar gi = 0; gi < 32; gi++) begin : g_chip
    chip_idx_t src;
    // Rotating right by rot chips means output chip gi comes from chip gi-rot.
    assign src        = chip_idx_t'(gi) - rot;
    assign chips_o[gi] = CHIP_SEQ_0[src] ^ (sym_i[3] & ((gi % 2) == 1));
  end

endmodule

// File: rtl/zigbee_chip_spreader.sv
// O-QPSK transmit spreader: takes PSDU bytes, emits two 32-chip symbols per byte
// (low nibble first), one chip per chip-rate strobe, gapless across bytes.
module zigbee_chip_spreader
  import zigbee_pkg::*;
#(
  parameter int   CHIPS     = 32,
  parameter logic IDLE_CHIP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inData,
  input  logic       inValid,
  output logic       outReady,
  input  logic       inChipEn,
  output logic       outChip,
  output logic       outChipValid,
  output logic       outSymStart,
  output logic       outBusy
);

  localparam chip_idx_t LAST_IDX = chip_idx_t'(CHIPS - 1);

  spread_state_t state_q;
  logic [7:0]    byte_q;
  logic          nib_q;
  chip_idx_t     idx_q;
  logic          chip_q;
  logic          chip_valid_q;
  logic          sym_start_q;

  symbol_t       sym_d;
  logic [0:31]   sym_chips;
  logic          last_chip;

  assign sym_d     = nib_q ? byte_q[7:4] : byte_q[3:0];
  assign last_chip = nib_q & (idx_q == LAST_IDX);

  zigbee_chip_lut u_lut (
    .sym_i   (sym_d),
    .chips_o (sym_chips)
  );

  // Ready during SEND only on the final chip strobe, so the next byte lands gaplessly.
  assign outReady     = (state_q == ST_IDLE) | ((state_q == ST_SEND) & last_chip & inChipEn);
  assign outChip      = chip_q;
  assign outChipValid = chip_valid_q;
  assign outSymStart  = sym_start_q;
  assign outBusy      = (state_q == ST_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_q       <= '0;
      nib_q        <= 1'b0;
      idx_q        <= '0;
      chip_q       <= IDLE_CHIP;
      chip_valid_q <= 1'b0;
      sym_start_q  <= 1'b0;
    end else begin
      chip_valid_q <= 1'b0;
      sym_start_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          chip_q <= IDLE_CHIP;
          if (inValid) begin
            byte_q  <= inData;
            nib_q   <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (inChipEn) begin
            chip_q       <= sym_chips[idx_q];
            chip_valid_q <= 1'b1;
            sym_start_q  <= (idx_q == '0);
            if (idx_q != LAST_IDX) begin
              idx_q <= idx_q + 5'd1;
            end else if (!nib_q) begin
              idx_q <= '0;
              nib_q <= 1'b1;
            end else if (inValid) begin
              byte_q <= inData;
              nib_q  <= 1'b0;
              idx_q  <= '0;
            end else begin
              nib_q   <= 1'b0;
              idx_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Bench for zigbee_chip_spreader: a byte-level reference model predicts every
// output each cycle from the PN table built by rotate/invert rules.
module tb_zigbee_chip_spreader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inData;
  logic       inValid;
  logic       outReady;
  logic       inChipEn;
  logic       outChip;
  logic       outChipValid;
  logic       outSymStart;
  logic       outBusy;

  zigbee_chip_spreader #(.CHIPS(32), .IDLE_CHIP(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .inData       (inData),
    .inValid      (inValid),
    .outReady     (outReady),
    .inChipEn     (inChipEn),
    .outChip      (outChip),
    .outChipValid (outChipValid),
    .outSymStart  (outSymStart),
    .outBusy      (outBusy)
  );

  always #5 clk = ~clk;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference PN table, chip i of symbol s is pn[s][31-i].
  logic [31:0] pn [16];

  // Stimulus controls
  logic [7:0] tx_q [$];
  int         en_mode   = 0;  // 0 every cycle, 1 every 4th, 2 random
  bit         rnd_valid = 1'b0;
  bit         acc_flag  = 1'b0;

  // Model state
  bit          started  = 1'b0;
  bit          m_active = 1'b0;
  int          m_pos    = 0;
  logic [7:0]  m_byte   = '0;
  logic        exp_valid = 1'b0;
  logic        exp_chip  = 1'b0;
  logic        exp_start = 1'b0;
  logic [127:0] obs;
  int          vld_cnt = 0;

  // Source driver: holds inData/inValid until the model reports acceptance.
  initial begin
    int en_cnt;
    en_cnt   = 0;
    inValid  = 1'b0;
    inData   = '0;
    inChipEn = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_flag) begin
        void'(tx_q.pop_front());
        inValid = 1'b0;
      end
      if (!inValid && tx_q.size() > 0 && (!rnd_valid || $urandom_range(1, 0) == 1)) begin
        inValid = 1'b1;
        inData  = tx_q[0];
      end
      case (en_mode)
        0: inChipEn = 1'b1;
        1: begin
          inChipEn = (en_cnt == 0);
          en_cnt   = (en_cnt + 1) % 4;
        end
        default: inChipEn = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Model + checker, evaluated at the falling edge.
  always @(negedge clk) begin
    logic ready_m;
    logic emit;
    logic idle_before;
    logic [3:0] s;
    if (started) begin
      check_eq("chip_valid", outChipValid, exp_valid);
      check_eq("chip", outChip, exp_chip);
      check_eq("sym_start", outSymStart, exp_start);
      check_eq("busy", outBusy, m_active);
    end
    if (outChipValid === 1'b1) begin
      obs = {obs[126:0], outChip};
      vld_cnt++;
    end
    acc_flag = 1'b0;
    if (rst) begin
      m_active  = 1'b0;
      m_pos     = 0;
      exp_valid = 1'b0;
      exp_chip  = 1'b0;
      exp_start = 1'b0;
      started   = 1'b1;
    end else if (started) begin
      idle_before = !m_active;
      ready_m     = !m_active || (m_pos == 63 && inChipEn);
      check_eq("ready", outReady, ready_m);
      emit      = m_active && inChipEn;
      exp_valid = emit;
      exp_start = 1'b0;
      if (emit) begin
        s         = (m_pos < 32) ? m_byte[3:0] : m_byte[7:4];
        exp_chip  = pn[s][31 - (m_pos % 32)];
        exp_start = ((m_pos % 32) == 0);
        m_pos++;
        if (m_pos == 64) m_active = 1'b0;
      end else if (idle_before) begin
        exp_chip = 1'b0;
      end
      if (ready_m && inValid) begin
        m_byte   = inData;
        m_pos    = 0;
        m_active = 1'b1;
        acc_flag = 1'b1;
      end
    end
  end

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || m_active || inValid) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("idle_timeout", 64'(n < max_cycles), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    vld_cnt = 0;
    obs     = '0;
  endtask

  initial begin
    rst = 1'b1;
    pn[0] = 32'hD9C3522E;
    for (int k = 1; k < 8; k++) pn[k] = {pn[k-1][3:0], pn[k-1][31:4]};
    for (int k = 0; k < 8; k++) pn[k+8] = pn[k] ^ 32'h55555555;

    // T1: reset with inValid and inChipEn held high
    en_mode = 0;
    tx_q.push_back(8'h5A);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle(400);

    // T2: single byte 0x80, chip enable every cycle
    start_test();
    tx_q.push_back(8'h80);
    wait_idle(400);
    check_eq("t2_count", 64'(vld_cnt), 64'd64);
    check_eq("t2_chips", obs[63:0], 64'hD9C3522E_8C96077B);

    // T3: back-to-back 0x10, 0x32
    start_test();
    tx_q.push_back(8'h10);
    tx_q.push_back(8'h32);
    wait_idle(600);
    check_eq("t3_count", 64'(vld_cnt), 64'd128);
    check_eq("t3_first_byte", obs[127:64], 64'hD9C3522E_ED9C3522);

    // T4: chip enable every 4th cycle, byte 0xFF
    en_mode = 1;
    start_test();
    tx_q.push_back(8'hFF);
    wait_idle(600);
    check_eq("t4_count", 64'(vld_cnt), 64'd64);

    // T5: reset at chip 17 of the low nibble, then a fresh byte
    en_mode = 0;
    start_test();
    tx_q.push_back(8'h3C);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (m_active && m_pos == 17) break;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("t5_dropped_chips", 64'(vld_cnt), 64'd17);
    tx_q.push_back(8'hA7);
    wait_idle(400);
    check_eq("t5_count", 64'(vld_cnt), 64'd81);

    // T6: random bytes, random valid gaps and chip strobes
    en_mode   = 2;
    rnd_valid = 1'b1;
    start_test();
    for (int i = 0; i < 40; i++) tx_q.push_back(8'($urandom_range(255, 0)));
    wait_idle(20000);
    check_eq("t6_count", 64'(vld_cnt), 64'd2560);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
